data_mem_arbiter: RTL

Single-port data-memory arbiter for the venera_cpu_1 subsystem. It lets one single-port synchronous RAM serve two requesters:
- the CPU data bus, which has separate read and write channels and cannot be stalled;
- a debug/loader port, which uses a request/acknowledge handshake.

A 2-entry posted-write FIFO absorbs CPU writes that collide with CPU reads. Read-after-write forwarding keeps the CPU's fixed one-cycle read latency coherent.

---
 rtl/data_mem_arbiter_pkg.sv | 10 +
 rtl/data_mem_arbiter_wr_post_fifo.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: default widths and RAM grant encoding shared by the data-memory arbiter.
package data_mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic [2:0] GNT_NONE   = 3'd0;
  localparam logic [2:0] GNT_CPU_RD = 3'd1;
  localparam logic [2:0] GNT_DRAIN  = 3'd2;
  localparam logic [2:0] GNT_CPU_WR = 3'd3;
  localparam logic [2:0] GNT_DBG    = 3'd4;
endpackage

// File: rtl/data_mem_arbiter_wr_post_fifo.sv
// data_mem_arbiter_wr_post_fifo: 2-entry posted-write FIFO; both slots exposed for read forwarding.
module data_mem_arbiter_wr_post_fifo #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          old_vld_o,
  output logic [AW-1:0] old_addr_o,
  output logic [DW-1:0] old_data_o,
  output logic          yng_vld_o,
  output logic [AW-1:0] yng_addr_o,
  output logic [DW-1:0] yng_data_o
);
  logic [1:0] cnt_q, cnt_d, left;
  logic [AW+DW-1:0] s0_q, s0_d, s1_q, s1_d;
  logic pop, push;
  // s0 is always the head; s1 only holds the younger entry when two are buffered
  always_comb begin
    pop = pop_i && cnt_q != 2'd0;
    push = push_i && (cnt_q != 2'd2 || pop);
    left = cnt_q - {1'b0, pop};
    s0_d = pop ? s1_q : s0_q;
    s1_d = s1_q;
    if (push && left == 2'd0) s0_d = {addr_i, data_i};
    if (push && left != 2'd0) s1_d = {addr_i, data_i};
    cnt_d = left + {1'b0, push};
  end
  always_ff @(posedge clk_i) begin
    cnt_q <= rst_i ? 2'd0 : cnt_d;
    s0_q <= s0_d;
    s1_q <= s1_d;
  end
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign old_vld_o = !empty_o;
  assign yng_vld_o = full_o;
  assign {old_addr_o, old_data_o} = s0_q;
  assign {yng_addr_o, yng_data_o} = s1_q;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port RAM between the unstallable CPU data bus and a debug port,
// posting colliding CPU writes and forwarding them to reads so the 1-cycle read latency stays coherent.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_wr,
  input  logic [ADDR_W-1:0] i_cpu_address_wr,
  input  logic [DATA_W-1:0] i_cpu_data_wr,
  input  logic              i_cpu_rd,
  input  logic [ADDR_W-1:0] i_cpu_address_rd,
  output logic [DATA_W-1:0] o_cpu_data_rd,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_address,
  input  logic [DATA_W-1:0] i_dbg_din,
  output logic              o_dbg_ack,
  output logic              o_dbg_valid,
  output logic [DATA_W-1:0] o_dbg_dout,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_overflow
);
  logic full, empty, old_vld, yng_vld, push, pop, drop;
  logic [ADDR_W-1:0] old_a, yng_a;
  logic [DATA_W-1:0] old_d, yng_d;
  logic [2:0] gnt;
  logic fwd_hit_q, fwd_hit_d, rd_vld_q, rd_vld_d, dbg_vld_q, dbg_vld_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d, dbg_hold_q, dbg_hold_d;
  data_mem_arbiter_wr_post_fifo #(.AW(ADDR_W), .DW(DATA_W)) u_fifo (
    .clk_i(i_clk), .rst_i(i_reset), .push_i(push), .pop_i(pop),
    .addr_i(i_cpu_address_wr), .data_i(i_cpu_data_wr), .full_o(full), .empty_o(empty),
    .old_vld_o(old_vld), .old_addr_o(old_a), .old_data_o(old_d),
    .yng_vld_o(yng_vld), .yng_addr_o(yng_a), .yng_data_o(yng_d)
  );
  // debug only wins with the FIFO empty and no CPU traffic, so it always sees coherent memory
  always_comb begin
    gnt = i_reset ? GNT_NONE : i_cpu_rd ? GNT_CPU_RD : !empty ? GNT_DRAIN :
          i_cpu_wr ? GNT_CPU_WR : i_dbg_req ? GNT_DBG : GNT_NONE;
    pop = gnt == GNT_DRAIN;
    push = i_cpu_wr && !i_reset && gnt != GNT_CPU_WR;
    drop = push && full && !pop;
    o_mem_en = gnt != GNT_NONE;
    o_mem_we = pop || gnt == GNT_CPU_WR || (gnt == GNT_DBG && i_dbg_we);
    o_mem_address = gnt == GNT_CPU_RD ? i_cpu_address_rd : pop ? old_a :
                    gnt == GNT_CPU_WR ? i_cpu_address_wr : i_dbg_address;
    o_mem_din = pop ? old_d : gnt == GNT_CPU_WR ? i_cpu_data_wr : i_dbg_din;
    o_dbg_ack = gnt == GNT_DBG;
    fwd_hit_d = i_cpu_rd && ((i_cpu_wr && i_cpu_address_wr == i_cpu_address_rd) ||
                (yng_vld && yng_a == i_cpu_address_rd) || (old_vld && old_a == i_cpu_address_rd));
    fwd_data_d = (i_cpu_wr && i_cpu_address_wr == i_cpu_address_rd) ? i_cpu_data_wr :
                 (yng_vld && yng_a == i_cpu_address_rd) ? yng_d : old_d;
    rd_vld_d = i_cpu_rd;
    dbg_vld_d = o_dbg_ack && !i_dbg_we;
    dbg_hold_d = dbg_vld_q ? i_mem_dout : dbg_hold_q;
    ovf_d = ovf_q || drop;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fwd_hit_q <= 1'b0;
      fwd_data_q <= '0;
      rd_vld_q <= 1'b0;
      dbg_vld_q <= 1'b0;
      dbg_hold_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      fwd_hit_q <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      rd_vld_q <= rd_vld_d;
      dbg_vld_q <= dbg_vld_d;
      dbg_hold_q <= dbg_hold_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_cpu_data_rd = !rd_vld_q ? '0 : fwd_hit_q ? fwd_data_q : i_mem_dout;
  assign o_dbg_valid = dbg_vld_q;
  assign o_dbg_dout = dbg_vld_q ? i_mem_dout : dbg_hold_q;
  assign o_overflow = ovf_q;
endmodule
